muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes, FSM states, widths.
package muldiv_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Signed variants take operand magnitudes and apply sign correction at the end.
  function automatic logic op_is_signed(input logic [OP_W-1:0] code);
    return (code == MULT) || (code == DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply, restoring divide, one bit per cycle,
// plus single-cycle MTHI/MTLO writes while idle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             divz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               nega_q, nega_d;
  logic               bzero_q, bzero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [ACC_W-1:0]   div_next;

  logic [ACC_W-1:0]   prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Operand magnitudes and signs taken straight from the inputs at start.
  always_comb begin
    sgn_op = op_is_signed(op);
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // One iteration step; acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opb_q};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Sign correction; a zero divisor forces an all-ones quotient, remainder falls out as a.
  always_comb begin
    prod_fix = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quot_fix = bzero_q ? '1
             : (neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]);
    rem_fix  = nega_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
  end

  // Controller: next state, datapath loads and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          case (op)
            MULT, MULTU, DIV, DIVU: begin
              state_d  = CALC;
              cnt_d    = '0;
              is_div_d = (op == DIV) || (op == DIVU);
              neg_d    = a_neg ^ b_neg;
              nega_d   = a_neg;
              bzero_d  = (b == '0);
              if ((op == DIV) || (op == DIVU)) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                opb_d = b_mag;
              end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                opb_d = a_mag;
              end
            end
            MTHI:    hi_d = a;
            MTLO:    lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d   = rem_fix;
            lo_d   = quot_fix;
            divz_d = bzero_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign divz = divz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: 32-bit instance for the main features, 8-bit instance for narrow corners.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, divz;
  logic [W-1:0]  hi, lo;

  logic          start8 = 1'b0;
  logic          cancel8 = 1'b0;
  logic [2:0]    op8 = 3'd0;
  logic [W8-1:0] a8 = '0;
  logic [W8-1:0] b8 = '0;
  logic          busy8, done8, divz8;
  logic [W8-1:0] hi8, lo8;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .divz(divz), .hi(hi), .lo(lo)
  );

  muldiv_seq #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel8),
    .busy(busy8), .done(done8), .divz(divz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  // Present one start pulse; returns at the falling edge just after the start edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; -1 if it never arrives.
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", done); end
    vectors++; if (divz !== 1'b0) begin miscompares++; $display("FAIL reset divz: got %b expected 0", divz); end
    vectors++; if (hi !== '0) begin miscompares++; $display("FAIL reset hi: got %h expected 0", hi); end
    vectors++; if (lo !== '0) begin miscompares++; $display("FAIL reset lo: got %h expected 0", lo); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult();
    logic [2:0]   vo [5];
    logic [W-1:0] va [5], vb [5], vh [5], vl [5];
    int n;
    vo = '{MULT, MULTU, MULT, MULTU, MULT};
    va = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    vb = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    vh = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vl = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001};
    for (int i = 0; i < 5; i++) begin
      issue(vo[i], va[i], vb[i]);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult[%0d] busy: got %b expected 1", i, busy); end
      wait_done(n);
      vectors++; if (n != 33) begin miscompares++; $display("FAIL mult[%0d] latency: got %0d expected 33", i, n); end
      vectors++; if (hi !== vh[i]) begin miscompares++; $display("FAIL mult[%0d] hi: got %h expected %h", i, hi, vh[i]); end
      vectors++; if (lo !== vl[i]) begin miscompares++; $display("FAIL mult[%0d] lo: got %h expected %h", i, lo, vl[i]); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mult[%0d] done pulse: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]   vo [10];
    logic [W-1:0] va [10], vb [10], vh [10], vl [10];
    logic         vz [10];
    int n;
    vo = '{DIV, DIV, DIV, DIV, DIVU, DIVU, DIVU, DIV, MULTU, DIVU};
    va = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100,
           32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB, 32'd5, 32'd9};
    vb = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7,
           32'd10, 32'd0, 32'd0, 32'd6, 32'd3};
    vh = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2,
           32'd5, 32'd7, 32'hFFFF_FFFB, 32'd0, 32'd0};
    vl = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'd14,
           32'h1999_9999, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd30, 32'd3};
    vz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      issue(vo[i], va[i], vb[i]);
      wait_done(n);
      vectors++; if (n != 33) begin miscompares++; $display("FAIL div[%0d] latency: got %0d expected 33", i, n); end
      vectors++; if (hi !== vh[i]) begin miscompares++; $display("FAIL div[%0d] hi: got %h expected %h", i, hi, vh[i]); end
      vectors++; if (lo !== vl[i]) begin miscompares++; $display("FAIL div[%0d] lo: got %h expected %h", i, lo, vl[i]); end
      vectors++; if (divz !== vz[i]) begin miscompares++; $display("FAIL div[%0d] divz: got %b expected %b", i, divz, vz[i]); end
    end
  endtask

  task automatic test_move();
    issue(MTHI, 32'h1234_5678, 32'd0);
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi hi: got %h expected 12345678", hi); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mthi done: got %b expected 0", done); end
    issue(MTLO, 32'h9ABC_DEF0, 32'd0);
    vectors++; if (lo !== 32'h9ABC_DEF0) begin miscompares++; $display("FAIL mtlo lo: got %h expected 9abcdef0", lo); end
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mtlo hi kept: got %h expected 12345678", hi); end
    issue(3'd7, 32'hFFFF_FFFF, 32'd1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL undef op busy: got %b expected 0", busy); end
    vectors++; if (lo !== 32'h9ABC_DEF0) begin miscompares++; $display("FAIL undef op lo: got %h expected 9abcdef0", lo); end
  endtask

  task automatic test_ignore_in_fin();
    issue(MULTU, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fin busy: got %b expected 0", busy); end
    start = 1'b1; op = MTLO; a = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL fin done: got %b expected 1", done); end
    vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL fin mtlo ignored lo: got %h expected 6", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL fin hi: got %h expected 0", hi); end
  endtask

  task automatic test_cancel();
    int dones;
    issue(MTHI, 32'hAAAA_AAAA, 32'd0);
    issue(MTLO, 32'h5555_5555, 32'd0);
    issue(MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cancel busy mid: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL cancel hi: got %h expected aaaaaaaa", hi); end
    vectors++; if (lo !== 32'h5555_5555) begin miscompares++; $display("FAIL cancel lo: got %h expected 55555555", lo); end
    dones = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL cancel no done: got %0d expected 0", dones); end
    vectors++; if (lo !== 32'h5555_5555) begin miscompares++; $display("FAIL cancel lo late: got %h expected 55555555", lo); end
    // cancel beats a same-cycle start in idle
    start = 1'b1; cancel = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel start busy: got %b expected 0", busy); end
    dones = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL cancel start done: got %0d expected 0", dones); end
  endtask

  task automatic test_capture();
    int n;
    issue(MULTU, 32'd6, 32'd7);
    a = 32'hFFFF_FFFF; b = 32'h0001_2345;
    wait_done(n);
    vectors++; if (n != 33) begin miscompares++; $display("FAIL capture latency: got %0d expected 33", n); end
    vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL capture lo: got %h expected 2a", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL capture hi: got %h expected 0", hi); end
  endtask

  task automatic test_reset_mid();
    int n, dones;
    issue(DIVU, 32'd1, 32'd0);
    wait_done(n);
    vectors++; if (divz !== 1'b1) begin miscompares++; $display("FAIL rstmid pre divz: got %b expected 1", divz); end
    issue(DIVU, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (hi !== '0) begin miscompares++; $display("FAIL rstmid hi: got %h expected 0", hi); end
    vectors++; if (lo !== '0) begin miscompares++; $display("FAIL rstmid lo: got %h expected 0", lo); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    vectors++; if (divz !== 1'b0) begin miscompares++; $display("FAIL rstmid divz: got %b expected 0", divz); end
    dones = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) dones++; end
    rst = 1'b1;
    repeat (30) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL rstmid no done: got %0d expected 0", dones); end
    issue(MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_done(n);
    vectors++; if (n != 33) begin miscompares++; $display("FAIL rstmid multu latency: got %0d expected 33", n); end
    vectors++; if (hi !== 32'd1) begin miscompares++; $display("FAIL rstmid multu hi: got %h expected 1", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL rstmid multu lo: got %h expected 0", lo); end
  endtask

  task automatic test_width8();
    logic [2:0]    vo [3];
    logic [W8-1:0] va [3], vb [3], vh [3], vl [3];
    int n;
    vo = '{DIV, MULT, DIVU};
    va = '{8'h80, 8'h80, 8'hFF};
    vb = '{8'hFF, 8'h80, 8'h10};
    vh = '{8'h00, 8'h40, 8'h0F};
    vl = '{8'h80, 8'h00, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start8 = 1'b1; op8 = vo[i]; a8 = va[i]; b8 = vb[i];
      @(negedge clk);
      start8 = 1'b0;
      n = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done8 === 1'b1) begin n = k; break; end
      end
      vectors++; if (n != 9) begin miscompares++; $display("FAIL w8[%0d] latency: got %0d expected 9", i, n); end
      vectors++; if (hi8 !== vh[i]) begin miscompares++; $display("FAIL w8[%0d] hi: got %h expected %h", i, hi8, vh[i]); end
      vectors++; if (lo8 !== vl[i]) begin miscompares++; $display("FAIL w8[%0d] lo: got %h expected %h", i, lo8, vl[i]); end
    end
    @(negedge clk);
    start8 = 1'b1; op8 = MTLO; a8 = 8'h5A;
    @(negedge clk);
    start8 = 1'b0;
    vectors++; if (lo8 !== 8'h5A) begin miscompares++; $display("FAIL w8 mtlo lo: got %h expected 5a", lo8); end
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL w8 mtlo busy: got %b expected 0", busy8); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_ignore_in_fin();
    test_cancel();
    test_capture();
    test_reset_mid();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
